// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: pointer widths and Gray conversion helpers used by both the
// write-side and read-side controllers.
package fifo_pkg;

    localparam int unsigned P_SIZE_DEF = 4;
    localparam int unsigned ADDR_W     = P_SIZE_DEF - 1;

    // Conversions run at a fixed wide width; callers zero-extend in and truncate out.
    localparam int unsigned PTR_MAX_W = 16;
    typedef logic [PTR_MAX_W-1:0] ptr_t;

    // Full when the write Gray pointer equals the read pointer with its two MSBs inverted.
    localparam ptr_t FULL_INV_BASE = ptr_t'(2'b11);

    function automatic ptr_t full_inv_mask(input int unsigned p_size);
        return FULL_INV_BASE << (p_size - 2);
    endfunction

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_gray_cnt.sv
// Registered binary + Gray counter with increment enable; next-state values are exposed so the
// owner can compute flags in the same cycle.
module fifo_gray_cnt
    import fifo_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         inc,
    output logic [W-1:0] bin,
    output logic [W-1:0] gray,
    output logic [W-1:0] bin_nxt,
    output logic [W-1:0] gray_nxt
);

    logic [W-1:0] bin_q;
    logic [W-1:0] gray_q;

    always_comb begin
        bin_nxt  = bin_q + W'(inc);
        gray_nxt = W'(bin2gray(ptr_t'(bin_nxt)));
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bin_q  <= '0;
            gray_q <= '0;
        end else begin
            bin_q  <= bin_nxt;
            gray_q <= gray_nxt;
        end
    end

    assign bin  = bin_q;
    assign gray = gray_q;

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-domain pointer and flag controller for the async FIFO: owns the write address and Gray
// write pointer, and produces registered FULL / ALMOST_FULL / FILL_LVL against the synced read pointer.
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned P_SIZE   = 4,
    parameter int unsigned AF_LEVEL = 6
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     W_INC,
    input  logic [P_SIZE-1:0]        RD_PTR_SYNC,
    output logic [$clog2(DEPTH)-1:0] W_ADDR,
    output logic                     W_CLKEN,
    output logic [P_SIZE-1:0]        W_PTR,
    output logic                     FULL,
    output logic                     ALMOST_FULL,
    output logic [P_SIZE-1:0]        FILL_LVL
);

    localparam logic [P_SIZE-1:0] FULL_INV = P_SIZE'(full_inv_mask(P_SIZE));
    localparam logic [P_SIZE-1:0] AF_THR   = P_SIZE'(AF_LEVEL);

    logic              w_acc;
    logic [P_SIZE-1:0] wbin;
    logic [P_SIZE-1:0] wbin_nxt;
    logic [P_SIZE-1:0] wgray_nxt;
    logic [P_SIZE-1:0] rbin;
    logic [P_SIZE-1:0] lvl_d, lvl_q;
    logic              full_d, full_q;
    logic              af_d, af_q;

    // Writes are dropped while full; no error is recorded.
    assign w_acc = W_INC & ~full_q;

    fifo_gray_cnt #(
        .W (P_SIZE)
    ) u_wptr (
        .CLK      (CLK),
        .RST      (RST),
        .inc      (w_acc),
        .bin      (wbin),
        .gray     (W_PTR),
        .bin_nxt  (wbin_nxt),
        .gray_nxt (wgray_nxt)
    );

    always_comb begin
        rbin   = P_SIZE'(gray2bin(ptr_t'(RD_PTR_SYNC)));
        full_d = (wgray_nxt == (RD_PTR_SYNC ^ FULL_INV));
        lvl_d  = wbin_nxt - rbin;
        af_d   = (lvl_d >= AF_THR);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            full_q <= 1'b0;
            lvl_q  <= '0;
            af_q   <= 1'b0;
        end else begin
            full_q <= full_d;
            lvl_q  <= lvl_d;
            af_q   <= af_d;
        end
    end

    assign W_ADDR      = wbin[$clog2(DEPTH)-1:0];
    assign W_CLKEN     = w_acc;
    assign FULL        = full_q;
    assign ALMOST_FULL = af_q;
    assign FILL_LVL    = lvl_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Bench for fifo_wr_ctrl: directed scenarios plus random traffic, scored against a
// write/read occupancy-count model through an expected-value queue.
module tb_fifo_wr_ctrl;

    localparam int DEPTH = 8;
    localparam int AFL   = 6;

    logic       CLK;
    logic       RST;
    logic       W_INC;
    logic [3:0] RD_PTR_SYNC;
    logic [2:0] W_ADDR;
    logic       W_CLKEN;
    logic [3:0] W_PTR;
    logic       FULL;
    logic       ALMOST_FULL;
    logic [3:0] FILL_LVL;

    fifo_wr_ctrl #(
        .DEPTH    (8),
        .P_SIZE   (4),
        .AF_LEVEL (6)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .W_INC       (W_INC),
        .RD_PTR_SYNC (RD_PTR_SYNC),
        .W_ADDR      (W_ADDR),
        .W_CLKEN     (W_CLKEN),
        .W_PTR       (W_PTR),
        .FULL        (FULL),
        .ALMOST_FULL (ALMOST_FULL),
        .FILL_LVL    (FILL_LVL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] ptr;
        logic [2:0] addr;
        logic       full;
        logic       af;
        logic       clken;
        logic [3:0] lvl;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_en   = 0;

    // Model: total accepted writes and total reads made visible via RD_PTR_SYNC.
    int wr_cnt = 0;
    int rd_cnt = 0;

    function automatic logic [3:0] gray4(input int x);
        logic [3:0] b;
        b = 4'(x);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after an edge and queue what the DUT must show this cycle.
    task automatic step(input bit inc, input int rd_new);
        exp_t e;
        int   lvl;
        @(posedge CLK);
        #1;
        lvl     = wr_cnt - rd_cnt;
        e.ptr   = gray4(wr_cnt);
        e.addr  = 3'(wr_cnt);
        e.lvl   = 4'(lvl);
        e.full  = (lvl == DEPTH);
        e.af    = (lvl >= AFL);
        e.clken = inc && !e.full;
        sb_q.push_back(e);
        W_INC       = inc;
        RD_PTR_SYNC = gray4(rd_new);
        if (e.clken) wr_cnt++;
        rd_cnt = rd_new;
    endtask

    logic [3:0] prev_ptr = '0;

    always @(negedge CLK) begin
        exp_t e;
        if (mon_en && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("W_PTR", int'(W_PTR), int'(e.ptr));
            chk("W_ADDR", int'(W_ADDR), int'(e.addr));
            chk("FULL", int'(FULL), int'(e.full));
            chk("ALMOST_FULL", int'(ALMOST_FULL), int'(e.af));
            chk("FILL_LVL", int'(FILL_LVL), int'(e.lvl));
            chk("W_CLKEN", int'(W_CLKEN), int'(e.clken));
            chk("ptr_one_bit_step", int'($countones(prev_ptr ^ W_PTR) <= 1), 1);
            prev_ptr <= W_PTR;
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_W_PTR"}, int'(W_PTR), 0);
        chk({tag, "_FULL"}, int'(FULL), 0);
        chk({tag, "_AF"}, int'(ALMOST_FULL), 0);
        chk({tag, "_FILL_LVL"}, int'(FILL_LVL), 0);
        chk({tag, "_W_ADDR"}, int'(W_ADDR), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish by %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int rd_new;
        RST         = 1'b0;
        W_INC       = 1'b0;
        RD_PTR_SYNC = '0;

        // Reset held: W_INC toggles across edges, nothing moves.
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            W_INC = i[0];
            #1;
            chk_zero("reset");
            chk("reset_W_CLKEN", int'(W_CLKEN), int'(W_INC));
        end
        @(negedge CLK);
        W_INC  = 1'b0;
        RST    = 1'b1;
        mon_en = 1;

        // First write after reset.
        step(1, 0);
        step(1, 0);
        chk("first_W_PTR", int'(W_PTR), 1);
        chk("first_W_ADDR", int'(W_ADDR), 1);
        chk("first_FILL_LVL", int'(FILL_LVL), 1);

        // Fill to DEPTH with the read pointer parked at zero.
        for (int i = 3; i <= 8; i++) begin
            step(1, 0);
            if (i == 7) chk("fill6_ALMOST_FULL", int'(ALMOST_FULL), 1);
        end
        step(1, 0);
        chk("fill8_FULL", int'(FULL), 1);
        chk("fill8_W_PTR", int'(W_PTR), 4'b1100);
        chk("fill8_FILL_LVL", int'(FILL_LVL), 8);
        #1;
        chk("write9_W_CLKEN", int'(W_CLKEN), 0);
        step(0, 0);
        chk("write9_W_PTR_held", int'(W_PTR), 4'b1100);

        // Release one entry.
        step(0, 1);
        step(0, 1);
        chk("release_FULL", int'(FULL), 0);
        chk("release_FILL_LVL", int'(FILL_LVL), 7);
        step(1, 1);
        chk("release_W_ADDR", int'(W_ADDR), 0);
        #1;
        chk("release_W_CLKEN", int'(W_CLKEN), 1);
        step(0, 1);

        // Streaming with the reader trailing closely; pointer wraps several times.
        for (int i = 0; i < 40; i++) begin
            rd_new = (wr_cnt - 2 > rd_cnt) ? wr_cnt - 2 : rd_cnt;
            step(1, rd_new);
        end
        step(0, wr_cnt - 3);
        chk("wrap_FILL_LVL", int'(FILL_LVL), 3);
        chk("wrap_FULL", int'(FULL), 0);

        // Simultaneous write and read at level 7.
        for (int i = 0; i < 4; i++) step(1, rd_cnt);
        step(1, rd_cnt + 1);
        chk("simul_pre_FILL_LVL", int'(FILL_LVL), 7);
        step(0, rd_cnt);
        chk("simul_FILL_LVL", int'(FILL_LVL), 7);
        chk("simul_FULL", int'(FULL), 0);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(2, 0) == 0) rd_new = rd_cnt;
            else rd_new = rd_cnt + int'($urandom_range(wr_cnt - rd_cnt, 0));
            step(($urandom_range(3, 0) != 0), rd_new);
        end

        // Reset in the middle of a burst at level 5.
        step(0, wr_cnt);
        for (int i = 0; i < 5; i++) step(1, rd_cnt);
        step(1, rd_cnt);
        chk("midrst_pre_FILL_LVL", int'(FILL_LVL), 5);
        mon_en = 0;
        sb_q.delete();
        #2;
        RST = 1'b0;
        #1;
        chk_zero("midrst_async");
        @(posedge CLK);
        #1;
        chk_zero("midrst_held");
        @(negedge CLK);
        W_INC       = 1'b0;
        RD_PTR_SYNC = '0;
        wr_cnt      = 0;
        rd_cnt      = 0;
        prev_ptr    = '0;
        RST         = 1'b1;
        mon_en      = 1;
        step(1, 0);
        step(1, 0);
        step(0, 0);
        step(0, 0);
        @(negedge CLK);
        @(negedge CLK);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_wr_ctrl.md
# fifo_wr_ctrl

Write-side pointer and flag controller for the asynchronous FIFO. It runs entirely in the write clock domain and owns the binary write address and the Gray-coded write pointer. It also produces the registered full and almost-full flags and a fill level, computed against the read pointer arriving from the read-to-write two-flop synchronizer. Its W_PTR output is the pointer that the write-to-read synchronizer carries into the read domain.

## Interface
- DEPTH, 8: FIFO entries; must equal 2^(P_SIZE-1).
- P_SIZE, 4: pointer width, i.e. address width + 1 wrap bit.
- AF_LEVEL, 6: fill level at or above which ALMOST_FULL asserts; legal range 1..DEPTH-1.
- CLK  in  1  write-domain clock.
- RST  in  1  asynchronous, active-low reset.
- W_INC  in  1  write request, one word per cycle when high.
- RD_PTR_SYNC  in  P_SIZE  Gray read pointer, already synchronized into CLK domain.
- W_ADDR  out  P_SIZE-1  binary address into FIFO memory.
- W_CLKEN  out  1  memory write enable, combinational = W_INC & ~FULL.
- W_PTR  out  P_SIZE  registered Gray write pointer, to the write-to-read synchronizer.
- FULL  out  1  registered full flag.
- ALMOST_FULL  out  1  registered, high when fill level >= AF_LEVEL.
- FILL_LVL  out  P_SIZE  registered occupancy as seen from the write side, 0..DEPTH.

## Operation
- Internal binary pointer wbin[P_SIZE-1:0]. W_ADDR = wbin[P_SIZE-2:0].
- Next pointer: wbin_nxt = wbin + (W_INC & ~FULL), modulo 2^P_SIZE. Wrap from all-ones to 0 is silent.
- wgray_nxt = wbin_nxt ^ (wbin_nxt >> 1). W_PTR is registered from wgray_nxt, with no combinational path to the output.
- Only one W_PTR bit changes per accepted write. A burst of writes must never produce a multi-bit change on W_PTR.
- Full test: full_nxt = (wgray_nxt == {~RD_PTR_SYNC[P_SIZE-1:P_SIZE-2], RD_PTR_SYNC[P_SIZE-3:0]}).
- Read binary: rbin = Gray-to-binary(RD_PTR_SYNC), computed by XOR prefix from the MSB down.
- Fill: lvl_nxt = (wbin_nxt - rbin), modulo 2^P_SIZE. The result is always 0..DEPTH.
- Registered outputs: FULL <= full_nxt; FILL_LVL <= lvl_nxt; ALMOST_FULL <= (lvl_nxt >= AF_LEVEL).
- Write while FULL: W_CLKEN=0 and the pointer holds; the request is dropped. There is no sticky error flag.
- Reset values: wbin=0, W_PTR=0, FULL=0, ALMOST_FULL=0, FILL_LVL=0. Therefore W_ADDR=0 and W_CLKEN=W_INC.
- Reset mid-operation: all state clears asynchronously and any in-flight write is discarded. The read side is reset by the same system reset.

## Timing
- Accepted write at edge N:
  - W_ADDR and W_CLKEN are valid in the cycle before edge N, and memory captures at edge N.
  - W_PTR, FULL, ALMOST_FULL and FILL_LVL reflect the write after edge N.
- Filling the last entry: FULL is high directly after the edge of the DEPTH-th unread write. It is never late, so there is no overrun.
- Read release:
  - A read-side pointer change reaches RD_PTR_SYNC 2 CLK edges after launch (external synchronizer).
  - FULL, ALMOST_FULL and FILL_LVL update 1 edge after that.
  - Release is pessimistic (late) by design and is never optimistic.
- Simultaneous write and RD_PTR_SYNC change in the same cycle: both are used in the same next-state computation. Level = old level + 1 − reads seen.
- W_INC held high with FULL high: no pointer motion and all outputs stable. Acceptance resumes the cycle FULL falls.

## Structure
- Shared FIFO package holds:
  - address width ADDR_W = P_SIZE-1;
  - bin2gray and gray2bin functions, also used by the read-side controller;
  - the full-compare MSB-inversion constant.
- Keep this block a single module, with the Gray conversion done by package functions.
- One natural sub-module is fifo_gray_cnt: a binary+Gray registered counter with increment enable. It is reused by the read controller, and it instantiates cleanly here for wbin/W_PTR.
- The synchronizer and memory stay outside this block.

## Test plan
All scenarios use DEPTH=8, P_SIZE=4, AF_LEVEL=6.
- Reset:
  - Stimulus: hold RST low, toggle W_INC.
  - Required: W_PTR=0000, FULL=0, ALMOST_FULL=0, FILL_LVL=0, W_ADDR=000.
  - Then: release RST and issue 1 write. Required: W_PTR=0001, W_ADDR=001, FILL_LVL=1.
- Fill:
  - Stimulus: RD_PTR_SYNC=0000, 8 consecutive writes.
  - After write 6: ALMOST_FULL=1.
  - After write 8: FULL=1, W_PTR=1100 (Gray of 8), FILL_LVL=8.
  - A 9th W_INC gives W_CLKEN=0, and W_PTR stays 1100.
- Release:
  - Stimulus: from full, set RD_PTR_SYNC=0001.
  - Required: FULL=0 and FILL_LVL=7 one edge later. The next write is accepted with W_ADDR=000.
- Wrap-around:
  - Stimulus: stream 40 writes while RD_PTR_SYNC tracks wbin−3 in Gray.
  - Required: wbin wraps 1111→0000, every consecutive W_PTR pair has Hamming distance 1, FULL never asserts, and FILL_LVL=3 at steady state.
- Simultaneous:
  - Stimulus: at level 7, write and advance RD_PTR_SYNC by one in the same cycle.
  - Required: FILL_LVL=7, FULL stays 0.
- Reset mid-burst:
  - Stimulus: drop RST at level 5 during an active write.
  - Required: all outputs clear immediately without waiting for CLK, and the interrupted write does not advance W_PTR.
